// File: rtl/lsu_byte_seq_if.sv
// lsu_byte_seq_if: bundles the core request/response handshake and the byte-wide RAM port.
//   slave  : the lsu_byte_seq view. It takes requests and rsp_ready/mem_rdata, and drives the
//            response and the RAM address/data/enable.
//   master : the environment view (core plus RAM), which is the mirror of slave.
interface lsu_byte_seq_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
);
    // core request
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [1:0]        req_size;
    logic              req_lu;
    // core response
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    // byte RAM port
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_lu, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_lu, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: load/store sequencer that splits a core request into byte accesses.
// It issues one byte per cycle, little-endian, lowest address first.
// Loads are assembled and then sign- or zero-extended. The result, or a store completion,
// is returned on a valid/ready response.
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : lsu_byte_seq_if.slave, which carries the request, the response and the byte RAM port
// Optional feature: defining MISALIGN_TRAP_EN turns a misaligned half or word into an
// error response with no RAM cycles. When it is not defined, misaligned accesses run byte-wise.
module lsu_byte_seq #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic          clk,
    input  logic          rstn,
    lsu_byte_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e            state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_rdata_q;
    logic              rsp_err_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic              we_q;
    logic              lu_q;
    logic [1:0]        size_q;
    logic [1:0]        idx_q;      // byte being accessed this cycle
    logic [1:0]        last_q;     // index of the final byte (N-1)
    logic [XLEN-9:0]   wsh_q;      // remaining store bytes, shifted down one byte per access
    logic [31:0]       asm_q;      // load assembly register

    logic              req_err;
    logic              accept;
    logic [31:0]       ld_full;
    logic [XLEN-1:0]   ld_ext;

    assign accept = bus.req_valid && req_ready_q;

    always_comb begin
        req_err = (bus.req_size == 2'b00);
`ifdef MISALIGN_TRAP_EN
        if (bus.req_size == 2'b10 && bus.req_addr[0])
            req_err = 1'b1;
        if (bus.req_size == 2'b11 && bus.req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // The final byte is merged straight from mem_rdata, so the response can be
    // registered on the same edge that samples it.
    always_comb begin
        ld_full = asm_q;
        ld_full[{idx_q, 3'b000} +: 8] = bus.mem_rdata;
        ld_ext = '0;
        case (size_q)
            2'b01: begin
                ld_ext      = {XLEN{~lu_q & ld_full[7]}};
                ld_ext[7:0] = ld_full[7:0];
            end
            2'b10: begin
                ld_ext       = {XLEN{~lu_q & ld_full[15]}};
                ld_ext[15:0] = ld_full[15:0];
            end
            default: ld_ext[31:0] = ld_full;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            we_q        <= 1'b0;
            lu_q        <= 1'b0;
            size_q      <= 2'b00;
            idx_q       <= 2'd0;
            last_q      <= 2'd0;
            wsh_q       <= '0;
            asm_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        we_q        <= bus.req_we;
                        lu_q        <= bus.req_lu;
                        size_q      <= bus.req_size;
                        idx_q       <= 2'd0;
                        last_q      <= (bus.req_size == 2'b11) ? 2'd3 :
                                       (bus.req_size == 2'b10) ? 2'd1 : 2'd0;
                        if (req_err) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            // Byte 0 goes out on the RAM port in the first ACCESS cycle.
                            state_q    <= ACCESS;
                            mem_we_q   <= bus.req_we;
                            mem_addr_q <= bus.req_addr[ADDR_W-1:0];
                            if (bus.req_we) begin
                                mem_wdata_q <= bus.req_wdata[7:0];
                                wsh_q       <= bus.req_wdata[XLEN-1:8];
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q)
                        asm_q[{idx_q, 3'b000} +: 8] <= bus.mem_rdata;
                    if (idx_q == last_q) begin
                        state_q     <= RESP;
                        mem_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? '0 : ld_ext;
                    end else begin
                        idx_q      <= idx_q + 2'd1;
                        mem_addr_q <= mem_addr_q + ADDR_W'(1);   // wraps modulo RAM size
                        if (we_q) begin
                            mem_wdata_q <= wsh_q[7:0];
                            wsh_q       <= wsh_q >> 8;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Only the low ADDR_W address bits reach the RAM.
    logic unused_addr;
    assign unused_addr = ^bus.req_addr[XLEN-1:ADDR_W];

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb_lsu_byte_seq: directed bench for lsu_byte_seq with a 4 KB byte RAM model.
module tb_lsu_byte_seq;

    logic clk;
    logic rstn;

    lsu_byte_seq_if #(.XLEN(32), .ADDR_W(12)) bus ();

    lsu_byte_seq #(.XLEN(32), .ADDR_W(12)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on rising edge, with a log of write addresses.
    logic [7:0]  ram [4096];
    logic [11:0] wr_addr [64];
    int          wr_cnt = 0;

    assign bus.mem_rdata = ram[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            ram[bus.mem_addr]      <= bus.mem_wdata;
            wr_addr[wr_cnt % 64]   <= bus.mem_addr;
            wr_cnt                 <= wr_cnt + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] rd_log [16];
    int          nrd;
    int          we_hi = 0;

    always @(posedge clk) if (bus.mem_we) we_hi <= we_hi + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait for its response. lat counts the accept edge as edge 1.
    // hold > 0 keeps rsp_ready low for that many cycles and checks the response stays stable.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input logic lu, input int hold,
                           output logic [31:0] rd, output logic err, output int lat);
        int n;
        rd  = '0;
        err = 1'b0;
        lat = 0;
        nrd = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_size  = sz;
        bus.req_lu    = lu;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 20) begin
            if (nrd < 16) rd_log[nrd] = bus.mem_addr;
            nrd++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.rsp_valid) begin
            chk("rsp_valid_timeout", 32'd0, 32'd1);
            return;
        end
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        for (int k = 0; k < hold; k++) begin
            chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", bus.rsp_rdata, rd);
            chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          w0;
        int          h0;
        logic [11:0] a0;

        rstn          = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_size  = 2'b00;
        bus.req_lu    = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #3 rstn = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        chk("rst_mem_we",    {31'd0, bus.mem_we},    32'd0);
        chk("rst_mem_addr",  {20'd0, bus.mem_addr},  32'd0);
        chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

        // Store a word, then load it back
        run_req(1'b1, 32'h010, 32'h8badf00d, 2'b11, 1'b0, 0, rd, err, lat);
        chk("stw_lat",   lat, 32'd5);
        chk("stw_rdata", rd,  32'd0);
        chk("stw_err",   {31'd0, err}, 32'd0);
        chk("ram10", {24'd0, ram[12'h010]}, 32'h0d);
        chk("ram11", {24'd0, ram[12'h011]}, 32'hf0);
        chk("ram12", {24'd0, ram[12'h012]}, 32'had);
        chk("ram13", {24'd0, ram[12'h013]}, 32'h8b);
        run_req(1'b0, 32'h010, 32'h0, 2'b11, 1'b0, 0, rd, err, lat);
        chk("ldw_rdata", rd,  32'h8badf00d);
        chk("ldw_lat",   lat, 32'd5);

        // Byte loads, signed and unsigned
        run_req(1'b1, 32'h020, 32'h00000080, 2'b01, 1'b0, 0, rd, err, lat);
        chk("stb_lat", lat, 32'd2);
        run_req(1'b0, 32'h020, 32'h0, 2'b01, 1'b0, 0, rd, err, lat);
        chk("ldb_s", rd, 32'hffffff80);
        chk("ldb_lat", lat, 32'd2);
        run_req(1'b0, 32'h020, 32'h0, 2'b01, 1'b1, 0, rd, err, lat);
        chk("ldb_u", rd, 32'h00000080);

        // Half loads, where mem_we must stay low throughout
        run_req(1'b1, 32'h030, 32'h0000f234, 2'b10, 1'b0, 0, rd, err, lat);
        chk("sth_lat", lat, 32'd3);
        h0 = we_hi;
        run_req(1'b0, 32'h030, 32'h0, 2'b10, 1'b0, 0, rd, err, lat);
        chk("ldh_s", rd, 32'hfffff234);
        run_req(1'b0, 32'h030, 32'h0, 2'b10, 1'b1, 0, rd, err, lat);
        chk("ldh_u", rd, 32'h0000f234);
        chk("ld_no_we", we_hi, h0);

        // Word store wrapping past the top of the RAM
        w0 = wr_cnt;
        run_req(1'b1, 32'hffe, 32'h11223344, 2'b11, 1'b0, 0, rd, err, lat);
        chk("wrap_cnt",  wr_cnt - w0, 32'd4);
        chk("wrap_a0",   {20'd0, wr_addr[(w0 + 0) % 64]}, 32'hffe);
        chk("wrap_a1",   {20'd0, wr_addr[(w0 + 1) % 64]}, 32'hfff);
        chk("wrap_a2",   {20'd0, wr_addr[(w0 + 2) % 64]}, 32'h000);
        chk("wrap_a3",   {20'd0, wr_addr[(w0 + 3) % 64]}, 32'h001);
        chk("wrap_dfff", {24'd0, ram[12'hfff]}, 32'h33);
        chk("wrap_d000", {24'd0, ram[12'h000]}, 32'h22);

        // Misaligned word load at 0x003
        run_req(1'b1, 32'h100, 32'h0, 2'b11, 1'b0, 0, rd, err, lat);  // aligned, leaves mem_addr at 0x103
        run_req(1'b1, 32'h003, 32'h04030201, 2'b01, 1'b0, 0, rd, err, lat);
        run_req(1'b1, 32'h004, 32'h04030202, 2'b01, 1'b0, 0, rd, err, lat);
        run_req(1'b1, 32'h005, 32'h00000003, 2'b01, 1'b0, 0, rd, err, lat);
        run_req(1'b1, 32'h006, 32'h00000004, 2'b01, 1'b0, 0, rd, err, lat);
        a0 = bus.mem_addr;
        w0 = wr_cnt;
        run_req(1'b0, 32'h003, 32'h0, 2'b11, 1'b0, 0, rd, err, lat);
`ifdef MISALIGN_TRAP_EN
        chk("mis_err",   {31'd0, err}, 32'd1);
        chk("mis_lat",   lat, 32'd1);
        chk("mis_rdata", rd, 32'd0);
        chk("mis_addr",  {20'd0, bus.mem_addr}, {20'd0, a0});
        chk("mis_nowr",  wr_cnt - w0, 32'd0);
`else
        chk("mis_err",   {31'd0, err}, 32'd0);
        chk("mis_rdata", rd, 32'h04030201);
        chk("mis_lat",   lat, 32'd5);
        chk("mis_ra0",   {20'd0, rd_log[0]}, 32'h003);
        chk("mis_ra3",   {20'd0, rd_log[3]}, 32'h006);
`endif

        // Illegal size 00
        a0 = bus.mem_addr;
        w0 = wr_cnt;
        run_req(1'b1, 32'h050, 32'hdeadbeef, 2'b00, 1'b0, 0, rd, err, lat);
        chk("sz0_err",   {31'd0, err}, 32'd1);
        chk("sz0_rdata", rd, 32'd0);
        chk("sz0_lat",   lat, 32'd1);
        chk("sz0_nowr",  wr_cnt - w0, 32'd0);
        chk("sz0_addr",  {20'd0, bus.mem_addr}, {20'd0, a0});

        // Response back-pressure for 5 cycles
        run_req(1'b0, 32'h020, 32'h0, 2'b01, 1'b0, 5, rd, err, lat);
        chk("hold_val", rd, 32'hffffff80);

        // Reset during the 2nd byte of a word store
        run_req(1'b1, 32'h040, 32'h0, 2'b11, 1'b0, 0, rd, err, lat);
        w0 = wr_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h040;
        bus.req_wdata = 32'ha1b2c3d4;
        bus.req_size  = 2'b11;
        bus.req_lu    = 1'b0;
        chk("mid_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);               // accept edge
        #1 bus.req_valid = 1'b0;
        @(posedge clk);               // byte 0 written here
        #2 rstn = 1'b0;
        #1;
        chk("mid_we_drop", {31'd0, bus.mem_we}, 32'd0);
        chk("mid_rdy0",    {31'd0, bus.req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("mid_nwr",  wr_cnt - w0, 32'd1);
        chk("mid_b0",   {24'd0, ram[12'h040]}, 32'hd4);
        chk("mid_b1",   {24'd0, ram[12'h041]}, 32'h00);
        rstn = 1'b1;
        @(posedge clk);
        #1 chk("mid_rdy1", {31'd0, bus.req_ready}, 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
